// File: rtl/glb_dummy_end_if.sv
// Bus interfaces used at the east end of the global buffer chain.
// packet_ifc bundles the write, read-request and read-response fields of a GLB packet.
// cfg_ifc is the configuration bus used by the glb and sram config daisy chains.

interface packet_ifc #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 64
);
    logic                wr_en;
    logic [DATA_W/8-1:0] wr_strb;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_data_valid;

    modport master (
        output wr_en, wr_strb, wr_addr, wr_data,
        output rd_en, rd_addr, rd_data, rd_data_valid
    );
    modport slave (
        input wr_en, wr_strb, wr_addr, wr_data,
        input rd_en, rd_addr, rd_data, rd_data_valid
    );
endinterface

interface cfg_ifc #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);
    logic              wr_en;
    logic              wr_clk_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic              rd_clk_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;

    modport master (
        output wr_en, wr_clk_en, wr_addr, wr_data, rd_en, rd_clk_en, rd_addr,
        input  rd_data, rd_data_valid
    );
    modport slave (
        input  wr_en, wr_clk_en, wr_addr, wr_data, rd_en, rd_clk_en, rd_addr,
        output rd_data, rd_data_valid
    );
endinterface

// File: rtl/glb_dummy_end.sv
// East terminator of the GLB tile chain.
// Turns processor read responses around, answers reads to non-existent tiles
// with a fixed pattern via a small in-order queue, counts unclaimed accesses
// and exposes them through a tiny status register file on the glb config chain.
// UQ_DEPTH must be a power of two, minimum 2.

module glb_dummy_end #(
    parameter logic [63:0] UNCLAIMED_RD_DATA   = 64'hDEAD_BEEF_DEAD_BEEF,
    parameter int          UQ_DEPTH            = 4,
    parameter int          NUM_GLB_TILES       = 16,
    parameter int          BANK_ADDR_WIDTH     = 17,
    parameter int          BANK_SEL_ADDR_WIDTH = 1,
    parameter int          GLB_ADDR_WIDTH      = 23,
    parameter int          AXI_ADDR_WIDTH      = 13,
    parameter int          AXI_DATA_WIDTH      = 32,
    parameter int          CGRA_CFG_DATA_WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    packet_ifc.slave   proc_packet_w2e_wsti,
    packet_ifc.master  proc_packet_e2w_wsto,
    packet_ifc.slave   strm_packet_w2e_wsti,
    cfg_ifc.slave      if_cfg_wst_s,
    cfg_ifc.slave      if_sram_cfg_wst_s,
    output logic       unclaimed_err_pulse
);
    localparam int TILE_LSB = BANK_ADDR_WIDTH + BANK_SEL_ADDR_WIDTH;
    localparam int TILE_W   = GLB_ADDR_WIDTH - TILE_LSB;
    // Queue only ever returns the same constant, so occupancy is all it needs to hold.
    localparam int UQ_CW    = $clog2(UQ_DEPTH) + 1;

    logic [TILE_W-1:0]         w_rd_tile;
    logic [TILE_W-1:0]         w_wr_tile;
    logic                      w_unc_rd;
    logic                      w_unc_wr;
    logic                      w_uq_empty;
    logic                      w_uq_full;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_drop;
    logic                      w_clear;
    logic [AXI_DATA_WIDTH-1:0] w_cfg_rd_val;
    logic                      w_unused;

    logic [UQ_CW-1:0]          r_uq_cnt;
    logic                      r_uq_ovf;
    logic [15:0]               r_rd_cnt;
    logic [15:0]               r_wr_cnt;
    logic [63:0]               r_rdrs_data;
    logic                      r_rdrs_vld;
    logic                      r_err_pulse;
    logic [AXI_DATA_WIDTH-1:0] r_cfg_rd_data;
    logic                      r_cfg_rd_vld;
    logic                      r_sram_rd_vld;

    assign w_rd_tile  = proc_packet_w2e_wsti.rd_addr[GLB_ADDR_WIDTH-1:TILE_LSB];
    assign w_wr_tile  = proc_packet_w2e_wsti.wr_addr[GLB_ADDR_WIDTH-1:TILE_LSB];
    assign w_unc_rd   = proc_packet_w2e_wsti.rd_en && (int'(w_rd_tile) >= NUM_GLB_TILES);
    assign w_unc_wr   = proc_packet_w2e_wsti.wr_en && (int'(w_wr_tile) >= NUM_GLB_TILES);

    // Turnaround responses own the output slot; the queue drains only in idle slots.
    assign w_uq_empty = (r_uq_cnt == '0);
    assign w_uq_full  = (r_uq_cnt == UQ_CW'(UQ_DEPTH));
    assign w_pop      = !proc_packet_w2e_wsti.rd_data_valid && !w_uq_empty;
    assign w_push     = w_unc_rd && (!w_uq_full || w_pop);
    assign w_drop     = w_unc_rd && w_uq_full && !w_pop;

    assign w_clear    = if_cfg_wst_s.wr_en
                     && (if_cfg_wst_s.wr_addr == AXI_ADDR_WIDTH'(12))
                     && if_cfg_wst_s.wr_data[0];

    // Status register read mux, sampled at the rd_en edge.
    always_comb begin
        w_cfg_rd_val = '0;
        if (if_cfg_wst_s.rd_addr == AXI_ADDR_WIDTH'(0)) begin
            w_cfg_rd_val = AXI_DATA_WIDTH'(r_rd_cnt);
        end else if (if_cfg_wst_s.rd_addr == AXI_ADDR_WIDTH'(4)) begin
            w_cfg_rd_val = AXI_DATA_WIDTH'(r_wr_cnt);
        end else if (if_cfg_wst_s.rd_addr == AXI_ADDR_WIDTH'(8)) begin
            w_cfg_rd_val = AXI_DATA_WIDTH'(r_uq_ovf);
        end
    end

    // Unclaimed-read queue occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_uq_cnt <= '0;
        end else begin
            r_uq_cnt <= r_uq_cnt + UQ_CW'(w_push) - UQ_CW'(w_pop);
        end
    end

    // Processor response register: turnaround first, then queued unclaimed reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdrs_data <= '0;
            r_rdrs_vld  <= 1'b0;
        end else if (proc_packet_w2e_wsti.rd_data_valid) begin
            r_rdrs_data <= proc_packet_w2e_wsti.rd_data;
            r_rdrs_vld  <= 1'b1;
        end else if (w_pop) begin
            r_rdrs_data <= UNCLAIMED_RD_DATA;
            r_rdrs_vld  <= 1'b1;
        end else begin
            r_rdrs_data <= '0;
            r_rdrs_vld  <= 1'b0;
        end
    end

    // Saturating access counters and sticky overflow; a clear overrides any update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_uq_ovf <= 1'b0;
        end else if (w_clear) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_uq_ovf <= 1'b0;
        end else begin
            if (w_unc_rd && (r_rd_cnt != 16'hFFFF)) r_rd_cnt <= r_rd_cnt + 16'd1;
            if (w_unc_wr && (r_wr_cnt != 16'hFFFF)) r_wr_cnt <= r_wr_cnt + 16'd1;
            if (w_drop) r_uq_ovf <= 1'b1;
        end
    end

    // Error pulse and config read responses, one cycle after the triggering edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_pulse   <= 1'b0;
            r_cfg_rd_data <= '0;
            r_cfg_rd_vld  <= 1'b0;
            r_sram_rd_vld <= 1'b0;
        end else begin
            r_err_pulse   <= w_unc_rd || w_unc_wr;
            r_cfg_rd_data <= if_cfg_wst_s.rd_en ? w_cfg_rd_val : '0;
            r_cfg_rd_vld  <= if_cfg_wst_s.rd_en;
            r_sram_rd_vld <= if_sram_cfg_wst_s.rd_en;
        end
    end

    assign proc_packet_e2w_wsto.wr_en         = 1'b0;
    assign proc_packet_e2w_wsto.wr_strb       = '0;
    assign proc_packet_e2w_wsto.wr_addr       = '0;
    assign proc_packet_e2w_wsto.wr_data       = '0;
    assign proc_packet_e2w_wsto.rd_en         = 1'b0;
    assign proc_packet_e2w_wsto.rd_addr       = '0;
    assign proc_packet_e2w_wsto.rd_data       = r_rdrs_data;
    assign proc_packet_e2w_wsto.rd_data_valid = r_rdrs_vld;

    assign unclaimed_err_pulse             = r_err_pulse;
    assign if_cfg_wst_s.rd_data            = r_cfg_rd_data;
    assign if_cfg_wst_s.rd_data_valid      = r_cfg_rd_vld;
    assign if_sram_cfg_wst_s.rd_data       = '0;
    assign if_sram_cfg_wst_s.rd_data_valid = r_sram_rd_vld;

    // Terminated inputs that carry nothing this block acts on.
    assign w_unused = ^{proc_packet_w2e_wsti.wr_strb, proc_packet_w2e_wsti.wr_data,
                        proc_packet_w2e_wsti.rd_addr[TILE_LSB-1:0],
                        proc_packet_w2e_wsti.wr_addr[TILE_LSB-1:0],
                        strm_packet_w2e_wsti.wr_en, strm_packet_w2e_wsti.wr_strb,
                        strm_packet_w2e_wsti.wr_addr, strm_packet_w2e_wsti.wr_data,
                        strm_packet_w2e_wsti.rd_en, strm_packet_w2e_wsti.rd_addr,
                        strm_packet_w2e_wsti.rd_data, strm_packet_w2e_wsti.rd_data_valid,
                        if_cfg_wst_s.wr_clk_en, if_cfg_wst_s.rd_clk_en,
                        if_cfg_wst_s.wr_data[AXI_DATA_WIDTH-1:1],
                        if_sram_cfg_wst_s.wr_en, if_sram_cfg_wst_s.wr_clk_en,
                        if_sram_cfg_wst_s.wr_addr, if_sram_cfg_wst_s.wr_data,
                        if_sram_cfg_wst_s.rd_clk_en, if_sram_cfg_wst_s.rd_addr,
                        CGRA_CFG_DATA_WIDTH};

endmodule

// File: tb/tb_glb_dummy_end.sv
// Self-checking bench for glb_dummy_end: directed scenarios plus random traffic,
// compared every cycle against a queue-based behavioural model.

module tb_glb_dummy_end;
    localparam int          NUM_TILES = 16;
    localparam int          TILE_LSB  = 18;
    localparam int          UQ_DEPTH  = 4;
    localparam logic [63:0] UNCLAIMED = 64'hDEAD_BEEF_DEAD_BEEF;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic err_pulse;

    packet_ifc #(.ADDR_W(23), .DATA_W(64)) p_w2e ();
    packet_ifc #(.ADDR_W(23), .DATA_W(64)) p_e2w ();
    packet_ifc #(.ADDR_W(23), .DATA_W(64)) s_w2e ();
    cfg_ifc    #(.ADDR_W(13), .DATA_W(32)) cfg ();
    cfg_ifc    #(.ADDR_W(23), .DATA_W(32)) sram ();

    glb_dummy_end #(
        .UNCLAIMED_RD_DATA(UNCLAIMED),
        .UQ_DEPTH(UQ_DEPTH),
        .NUM_GLB_TILES(NUM_TILES)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .proc_packet_w2e_wsti(p_w2e),
        .proc_packet_e2w_wsto(p_e2w),
        .strm_packet_w2e_wsti(s_w2e),
        .if_cfg_wst_s(cfg),
        .if_sram_cfg_wst_s(sram),
        .unclaimed_err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // behavioural model state
    logic [63:0] uq[$];
    int          m_rd, m_wr;
    bit          m_ovf;
    logic [63:0] e_data;
    logic [31:0] e_cdata;
    bit          e_vld, e_pulse, e_cvld, e_svld;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] reg_val(input logic [12:0] a);
        case (a)
            13'h0:   return 32'(m_rd);
            13'h4:   return 32'(m_wr);
            13'h8:   return 32'(m_ovf);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [22:0] addr_in_tile(input int tile);
        logic [22:0] a;
        a = 23'($urandom);
        a[22:18] = 5'(tile);
        return a;
    endfunction

    task automatic idle();
        p_w2e.wr_en = 0; p_w2e.wr_strb = '0; p_w2e.wr_addr = '0; p_w2e.wr_data = '0;
        p_w2e.rd_en = 0; p_w2e.rd_addr = '0; p_w2e.rd_data = '0; p_w2e.rd_data_valid = 0;
        s_w2e.wr_en = 0; s_w2e.wr_strb = '0; s_w2e.wr_addr = '0; s_w2e.wr_data = '0;
        s_w2e.rd_en = 0; s_w2e.rd_addr = '0; s_w2e.rd_data = '0; s_w2e.rd_data_valid = 0;
        cfg.wr_en = 0; cfg.wr_clk_en = 0; cfg.wr_addr = '0; cfg.wr_data = '0;
        cfg.rd_en = 0; cfg.rd_clk_en = 0; cfg.rd_addr = '0;
        sram.wr_en = 0; sram.wr_clk_en = 0; sram.wr_addr = '0; sram.wr_data = '0;
        sram.rd_en = 0; sram.rd_clk_en = 0; sram.rd_addr = '0;
    endtask

    // Advance the model with the inputs now applied, clock once, then compare.
    task automatic step();
        bit unc_rd, unc_wr, clr;
        if (!reset_n) begin
            uq.delete(); m_rd = 0; m_wr = 0; m_ovf = 0;
            e_vld = 0; e_data = '0; e_pulse = 0; e_cvld = 0; e_cdata = '0; e_svld = 0;
        end else begin
            unc_rd = p_w2e.rd_en && (int'(p_w2e.rd_addr >> TILE_LSB) >= NUM_TILES);
            unc_wr = p_w2e.wr_en && (int'(p_w2e.wr_addr >> TILE_LSB) >= NUM_TILES);
            if (p_w2e.rd_data_valid) begin
                e_vld = 1; e_data = p_w2e.rd_data;
            end else if (uq.size() > 0) begin
                e_vld = 1; e_data = uq.pop_front();
            end else begin
                e_vld = 0; e_data = '0;
            end
            if (unc_rd) begin
                if (uq.size() < UQ_DEPTH) uq.push_back(UNCLAIMED);
                else m_ovf = 1;
            end
            e_pulse = unc_rd || unc_wr;
            e_cvld  = cfg.rd_en;
            e_cdata = reg_val(cfg.rd_addr);
            e_svld  = sram.rd_en;
            clr = cfg.wr_en && (cfg.wr_addr == 13'hC) && cfg.wr_data[0];
            if (unc_rd && m_rd < 65535) m_rd++;
            if (unc_wr && m_wr < 65535) m_wr++;
            if (clr) begin m_rd = 0; m_wr = 0; m_ovf = 0; end
        end
        @(posedge clk);
        #1;
        chk("rdrs_vld", 64'(p_e2w.rd_data_valid), 64'(e_vld));
        chk("rdrs_data", p_e2w.rd_data, e_data);
        chk("err_pulse", 64'(err_pulse), 64'(e_pulse));
        chk("cfg_vld", 64'(cfg.rd_data_valid), 64'(e_cvld));
        if (e_cvld) chk("cfg_data", 64'(cfg.rd_data), 64'(e_cdata));
        chk("sram_vld", 64'(sram.rd_data_valid), 64'(e_svld));
        if (e_svld) chk("sram_data", 64'(sram.rd_data), 64'h0);
        chk("e2w_req", 64'({p_e2w.wr_en, p_e2w.rd_en}), 64'h0);
    endtask

    task automatic cfg_read(input logic [12:0] a, output logic [31:0] d);
        idle();
        cfg.rd_en = 1; cfg.rd_addr = a;
        step();
        d = cfg.rd_data;
        idle();
    endtask

    initial begin
        logic [31:0] d;
        logic [12:0] cfg_addrs [5];
        int          n_dead, n_vld;
        cfg_addrs[0] = 13'h0; cfg_addrs[1] = 13'h4; cfg_addrs[2] = 13'h8;
        cfg_addrs[3] = 13'hC; cfg_addrs[4] = 13'h10;

        // reset: outputs held low even with traffic applied
        idle();
        p_w2e.rd_en = 1; p_w2e.rd_addr = addr_in_tile(20);
        p_w2e.rd_data_valid = 1; cfg.rd_en = 1; sram.rd_en = 1;
        repeat (3) step();
        idle();
        reset_n = 1;
        step();

        // single unclaimed read: pulse after 1 cycle, response after 2
        p_w2e.rd_en = 1; p_w2e.rd_addr = addr_in_tile(16);
        step();
        chk("s36_pulse", 64'(err_pulse), 64'h1);
        idle();
        step();
        chk("s36_rdrs", {63'(p_e2w.rd_data_valid), 1'b0} | 64'(p_e2w.rd_data == UNCLAIMED),
            {63'h1, 1'b0} | 64'h1);
        step();
        cfg_read(13'h0, d);
        chk("s36_rd_cnt", 64'(d), 64'h1);

        // 6 turnaround responses against 5 unclaimed reads
        for (int i = 0; i < 6; i++) begin
            idle();
            p_w2e.rd_data_valid = 1; p_w2e.rd_data = {$urandom, $urandom};
            if (i < 5) begin p_w2e.rd_en = 1; p_w2e.rd_addr = addr_in_tile(16 + i); end
            step();
        end
        idle();
        n_dead = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (p_e2w.rd_data_valid && p_e2w.rd_data == UNCLAIMED) n_dead++;
        end
        chk("s37_queued", 64'(n_dead), 64'd4);
        cfg_read(13'h8, d);
        chk("s37_ovf", 64'(d), 64'h1);

        // clear coincident with an unclaimed read
        idle();
        cfg.wr_en = 1; cfg.wr_addr = 13'hC; cfg.wr_data = 32'h1;
        p_w2e.rd_en = 1; p_w2e.rd_addr = addr_in_tile(31);
        step();
        idle();
        step();
        cfg_read(13'h0, d);
        chk("s39_rd_cnt", 64'(d), 64'h0);
        cfg_read(13'h8, d);
        chk("s39_ovf", 64'(d), 64'h0);

        // sram reads anywhere, glb read of an unmapped address
        for (int i = 0; i < 4; i++) begin
            idle();
            sram.rd_en = 1; sram.rd_addr = 23'($urandom); sram.rd_clk_en = 1'($urandom);
            step();
            idle();
            step();
        end
        cfg_read(13'h10, d);
        chk("s40_cfg_0x10", 64'(d), 64'h0);

        // random mixed traffic
        for (int i = 0; i < 400; i++) begin
            idle();
            p_w2e.rd_data_valid = ($urandom_range(0, 3) == 0);
            p_w2e.rd_data = {$urandom, $urandom};
            p_w2e.rd_en = ($urandom_range(0, 2) == 0);
            p_w2e.rd_addr = addr_in_tile($urandom_range(0, 31));
            p_w2e.wr_en = ($urandom_range(0, 3) == 0);
            p_w2e.wr_addr = addr_in_tile($urandom_range(0, 31));
            p_w2e.wr_data = {$urandom, $urandom};
            s_w2e.wr_en = 1'($urandom); s_w2e.rd_en = 1'($urandom);
            s_w2e.rd_data_valid = 1'($urandom); s_w2e.wr_data = {$urandom, $urandom};
            cfg.rd_en = ($urandom_range(0, 2) == 0);
            cfg.rd_addr = cfg_addrs[$urandom_range(0, 4)];
            cfg.rd_clk_en = 1'($urandom);
            cfg.wr_en = ($urandom_range(0, 24) == 0);
            cfg.wr_addr = cfg_addrs[$urandom_range(0, 4)];
            cfg.wr_data = $urandom; cfg.wr_clk_en = 1'($urandom);
            sram.rd_en = 1'($urandom); sram.rd_addr = 23'($urandom);
            sram.wr_en = 1'($urandom); sram.wr_data = $urandom;
            step();
        end
        idle();
        repeat (6) step();

        // write counter saturation
        idle();
        p_w2e.wr_en = 1;
        for (int i = 0; i < 70000; i++) begin
            p_w2e.wr_addr = addr_in_tile($urandom_range(16, 31));
            step();
        end
        cfg_read(13'h4, d);
        chk("s38_wr_sat", 64'(d), 64'h0000FFFF);

        // reset mid-operation with three queued entries
        for (int i = 0; i < 3; i++) begin
            idle();
            p_w2e.rd_data_valid = 1; p_w2e.rd_data = {$urandom, $urandom};
            p_w2e.rd_en = 1; p_w2e.rd_addr = addr_in_tile(17);
            cfg.rd_en = 1; cfg.rd_addr = 13'h0;
            step();
        end
        reset_n = 0;
        idle();
        repeat (2) step();
        reset_n = 1;
        n_vld = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (p_e2w.rd_data_valid || cfg.rd_data_valid) n_vld++;
        end
        chk("s41_no_resp", 64'(n_vld), 64'h0);
        cfg_read(13'h0, d);
        chk("s41_rd_cnt", 64'(d), 64'h0);
        cfg_read(13'h4, d);
        chk("s41_wr_cnt", 64'(d), 64'h0);
        cfg_read(13'h8, d);
        chk("s41_ovf", 64'(d), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
